// File: rtl/fp_sub_seq.sv
// Sequential binary32 subtractor: result = a + (-b), computed over
// ALIGN/SUB/NORM stages with truncation, flushed denormals and quiet-NaN on specials.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   ALIGN | pick the larger exponent, shift the smaller mantissa right
//   SUB   | add or subtract magnitudes, resolve the sign
//   NORM  | one normalisation step per cycle, pack the result when done
//   DONE  | result presented until the consumer takes it
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b;
  logic        r_nan;
  logic [7:0]  r_exp;
  logic [23:0] r_m_big, r_m_small;
  logic        r_s_big, r_s_small;
  logic [24:0] r_mant;
  logic        r_sign;
  logic [31:0] r_result;

  logic [7:0]  w_ea, w_eb, w_diff;
  logic [23:0] w_ma, w_mb;
  logic        w_a_big;
  logic [23:0] w_m_shift;
  logic [24:0] w_sub_mant;
  logic        w_sub_sign;
  logic [7:0]  w_exp_inc;
  logic        w_norm_done;
  logic [31:0] w_pack;

  assign w_ea      = r_a[30:23];
  assign w_eb      = r_b[30:23];
  assign w_ma      = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
  assign w_mb      = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
  assign w_a_big   = (w_ea >= w_eb);
  assign w_diff    = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_m_shift = (w_diff >= 8'd25) ? 24'd0 : ((w_a_big ? w_mb : w_ma) >> w_diff);

  always_comb begin
    w_sub_mant = 25'd0;
    w_sub_sign = 1'b0;
    if (r_s_big == r_s_small) begin
      w_sub_mant = {1'b0, r_m_big} + {1'b0, r_m_small};
      w_sub_sign = r_s_big;
    end else if (r_m_big > r_m_small) begin
      w_sub_mant = {1'b0, r_m_big - r_m_small};
      w_sub_sign = r_s_big;
    end else if (r_m_small > r_m_big) begin
      w_sub_mant = {1'b0, r_m_small - r_m_big};
      w_sub_sign = r_s_small;
    end
  end

  assign w_exp_inc   = r_exp + 8'd1;
  assign w_norm_done = r_nan || r_mant[24] || (r_mant == 25'd0) || r_mant[23] || (r_exp == 8'd1);

  always_comb begin
    w_pack = 32'd0;
    if (r_nan)
      w_pack = 32'h7FC0_0000;
    else if (r_mant[24])
      w_pack = (w_exp_inc == 8'hFF) ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_exp_inc, r_mant[23:1]};
    else if (r_mant == 25'd0)
      w_pack = 32'd0;
    else if (r_mant[23])
      w_pack = {r_sign, r_exp, r_mant[22:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ALIGN;
      end
      S_ALIGN: w_next = S_SUB;
      S_SUB:   w_next = S_NORM;
      S_NORM:  if (w_norm_done) w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_nan     <= 1'b0;
      r_exp     <= 8'd0;
      r_m_big   <= 24'd0;
      r_m_small <= 24'd0;
      r_s_big   <= 1'b0;
      r_s_small <= 1'b0;
      r_mant    <= 25'd0;
      r_sign    <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= {~b[31], b[30:0]};
        end
        S_ALIGN: begin
          r_nan     <= (w_ea == 8'hFF) || (w_eb == 8'hFF);
          r_exp     <= w_a_big ? w_ea : w_eb;
          r_m_big   <= w_a_big ? w_ma : w_mb;
          r_m_small <= w_m_shift;
          r_s_big   <= w_a_big ? r_a[31] : r_b[31];
          r_s_small <= w_a_big ? r_b[31] : r_a[31];
        end
        S_SUB: begin
          r_mant <= w_sub_mant;
          r_sign <= w_sub_sign;
        end
        S_NORM: begin
          // Underflow (exp == 1 without a leading one) falls through to the +0 default.
          if (w_norm_done) begin
            r_result <= w_pack;
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed corner cases plus random
// operands against an integer-arithmetic reference model.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  fp_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer sum of aligned mantissas, then normalise by rule.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int ex, ey, mx, my, e, d, s, mag;
    bit neg;
    lat = 3;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : (int'(x[22:0]) + (1 << 23));
    my = (ey == 0) ? 0 : (int'(y[22:0]) + (1 << 23));
    if (ex == 255 || ey == 255) begin
      r = 32'h7FC0_0000;
      return;
    end
    if (ex >= ey) begin
      e = ex; d = ex - ey;
      my = (d >= 25) ? 0 : (my >> d);
    end else begin
      e = ey; d = ey - ex;
      mx = (d >= 25) ? 0 : (mx >> d);
    end
    s   = (x[31] ? -mx : mx) + (y[31] ? my : -my);
    neg = (s < 0);
    mag = neg ? -s : s;
    if (mag == 0) begin
      r = 32'd0;
      return;
    end
    if (mag >= (1 << 24)) begin
      e++;
      mag = mag >> 1;
      r = (e == 255) ? {neg, 8'hFF, 23'd0} : {neg, 8'(e), 23'(mag)};
      return;
    end
    forever begin
      if (mag >= (1 << 23)) begin
        r = {neg, 8'(e), 23'(mag)};
        return;
      end
      if (e == 1) begin
        r = 32'd0;
        return;
      end
      mag = mag << 1;
      e--;
      lat++;
    end
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int hold,
                        input string tag);
    logic [31:0] er, held;
    int el, lat;
    bit seen;
    model(xa, xb, er, el);
    @(negedge clk);
    chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = out_valid;
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, result, er);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_result"}, result, held);
      chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " release_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  eb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h40A0_0000, 32'h4040_0000, 0, "5-3");
    run_op(32'h3F80_0000, 32'hBF80_0000, 0, "1-(-1)");
    run_op(32'h4040_0000, 32'h4040_0000, 0, "3-3");
    run_op(32'h3F80_0000, 32'h3F80_0001, 0, "1-1ulp");
    run_op(32'h40A0_0000, 32'h4040_0000, 5, "backpressure");
    run_op(32'h7F80_0000, 32'h3F80_0000, 0, "inf-1");
    run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 0, "overflow");
    run_op(32'h0000_0000, 32'h0000_0000, 0, "0-0");
    run_op(32'h0080_0001, 32'h0080_0000, 0, "underflow");
    run_op(32'h3F80_0000, 32'h0000_0000, 0, "1-0");

    // Abort a long normalisation with a one-cycle reset.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort no_result", 32'(out_valid), 32'd0);
    end
    run_op(32'h40A0_0000, 32'h4040_0000, 0, "after_abort");

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: rb = {1'($urandom), ra[30:23], 23'($urandom)};
        default: begin
          eb = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
          rb = {1'($urandom), eb, 23'($urandom)};
        end
      endcase
      run_op(ra, rb, $urandom_range(0, 2), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
